// File: rtl/alu_add_sched.sv
// alu_add_sched: one W-bit two's-complement adder shared by NREQ requesters.
// Round-robin grant in IDLE, one cycle of arithmetic in EXEC, and the result is
// held in RESP until the consumer takes it. Only one operation is in flight.
// Optional feature macro: ALU_SUB_EN. When it is defined, req_sub selects A-B.
// When it is undefined, req_sub is ignored and every operation is A+B.
// The carry-based overflow logic assumes W >= 2.
module alu_add_sched #(
    parameter int NREQ = 2,
    parameter int W    = 64,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_zf,
    output logic              rsp_sf,
    output logic              rsp_of
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_sub;

    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_sum;
    logic           r_zf;
    logic           r_sf;
    logic           r_of;

    logic           w_found;
    logic [IDW-1:0] w_grant;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic           w_sel_sub;
    logic           w_accept;
    logic           w_rsp_fire;
    logic [IDW-1:0] w_rr_next;

    logic           w_sub_eff;
    logic [W-1:0]   w_b_eff;
    logic [W:0]     w_full;
    logic [W-1:0]   w_low;

`ifdef ALU_SUB_EN
    assign w_sub_eff = r_sub;
`else
    // Subtract disabled: the latched flag is deliberately left unconsumed.
    logic w_sub_unused;
    assign w_sub_eff    = 1'b0;
    assign w_sub_unused = r_sub;
`endif

    // Round-robin search: first valid requester at or after r_rr_ptr, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found   = 1'b0;
        w_grant   = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found   = 1'b1;
                w_grant   = IDW'(idx);
                w_sel_a   = req_a[idx*W +: W];
                w_sel_b   = req_b[idx*W +: W];
                w_sel_sub = req_sub[idx];
            end
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && w_found;
    assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;
    assign w_rr_next  = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

    // Shared adder: A + (sub ? ~B : B) + sub. The low slice exposes the carry into the MSB.
    assign w_b_eff = w_sub_eff ? ~r_b : r_b;
    assign w_full  = {1'b0, r_a} + {1'b0, w_b_eff} + (W+1)'(w_sub_eff);
    assign w_low   = {1'b0, r_a[W-2:0]} + {1'b0, w_b_eff[W-2:0]} + W'(w_sub_eff);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the one-hot grant strobe.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_EXEC;
                    // Gated by rst_n so no grant is shown while reset is applied.
                    req_ready[w_grant] = rst_n;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture on grant, result and flag capture in EXEC, pointer advance on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_rsp_id <= '0;
            r_sum    <= '0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id  <= w_grant;
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_sub <= w_sel_sub;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_id <= r_id;
                r_sum    <= w_full[W-1:0];
                r_zf     <= (w_full[W-1:0] == '0);
                r_sf     <= w_full[W-1];
                r_of     <= w_low[W-1] ^ w_full[W];
            end
            if (w_rsp_fire) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_sum;
    assign rsp_zf    = r_zf;
    assign rsp_sf    = r_sf;
    assign rsp_of    = r_of;

endmodule

// File: tb/tb_alu_add_sched.sv
// Testbench for alu_add_sched (NREQ=2, W=64). Directed cases first, then random
// traffic. The expectations come from a plain arithmetic model and a
// round-robin pointer model. The test follows ALU_SUB_EN in the same way the design does.
module tb_alu_add_sched;

    localparam int NREQ = 2;
    localparam int W    = 64;
`ifdef ALU_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_zf;
    logic              rsp_sf;
    logic              rsp_of;

    alu_add_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_zf    (rsp_zf),
        .rsp_sf    (rsp_sf),
        .rsp_of    (rsp_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester-side view: pending op per requester.
    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic         op_s [NREQ];
    logic         v    [NREQ];

    int           m_rr;
    int           last_grant;
    logic [W-1:0] last_sum;
    logic         last_zf, last_of;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_a[i*W +: W]    = op_a[i];
            req_b[i*W +: W]    = op_b[i];
            req_sub[i]         = op_s[i];
        end
    endtask

    // Reference arithmetic: wrapped sum/difference and signed-overflow by operand/result signs.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] sum, output logic zf, output logic sf, output logic of);
        logic do_sub;
        do_sub = s && SUB_EN;
        sum    = do_sub ? a - b : a + b;
        zf     = (sum == 0);
        sf     = sum[W-1];
        if (do_sub) of = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
        else        of = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One full transaction starting in IDLE; ends in the following IDLE cycle.
    // hold = cycles of rsp_ready low in RESP; keep = whether the winner re-requests.
    task automatic serve(input int hold, input bit keep);
        int g;
        logic [W-1:0] esum;
        logic ezf, esf, eof;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        if (g < 0) begin
            $display("FAIL serve_setup: got no pending requester expected one");
            n_checks++;
            return;
        end
        drive();
        #1;
        check("grant", 64'(req_ready), 64'(1) << g);
        last_grant = (req_ready == 2'b10) ? 1 : 0;
        model(op_a[g], op_b[g], op_s[g], esum, ezf, esf, eof);
        @(posedge clk);
        @(negedge clk);
        // Winner moves on: new operands show the DUT latched the old ones.
        op_a[g] = pick();
        op_b[g] = pick();
        op_s[g] = 1'($urandom);
        v[g]    = keep;
        drive();
        #1;
        check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        check("exec_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("resp_req_ready", 64'(req_ready), 64'(0));
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_sum", rsp_sum, esum);
        check("rsp_zf", 64'(rsp_zf), 64'(ezf));
        check("rsp_sf", 64'(rsp_sf), 64'(esf));
        check("rsp_of", 64'(rsp_of), 64'(eof));
        last_sum = rsp_sum;
        last_zf  = rsp_zf;
        last_of  = rsp_of;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_sum", rsp_sum, esum);
            check("hold_id", 64'(rsp_id), 64'(g));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("post_rsp_valid", 64'(rsp_valid), 64'(0));
        m_rr = (g + 1) % NREQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_s[i] = 1'b0; v[i] = 1'b1;
        end
        drive();
        m_rr = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_sum", rsp_sum, 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_flags", {61'd0, rsp_zf, rsp_sf, rsp_of}, 64'(0));
        v[0] = 1'b0; v[1] = 1'b0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain add.
        v[0] = 1'b1; op_a[0] = 64'd5; op_b[0] = 64'd7; op_s[0] = 1'b0;
        serve(0, 0);
        check("add_sum_const", last_sum, 64'd12);
        check("add_grant_const", 64'(last_grant), 64'(0));

        // Signed overflow into the sign bit.
        v[0] = 1'b1; op_a[0] = 64'h7FFF_FFFF_FFFF_FFFF; op_b[0] = 64'd1; op_s[0] = 1'b0;
        serve(0, 0);
        check("ovf_sum_const", last_sum, 64'h8000_0000_0000_0000);
        check("ovf_of_const", 64'(last_of), 64'(1));

        // Unsigned wrap to zero: carry out discarded, no signed overflow.
        v[0] = 1'b1; op_a[0] = '1; op_b[0] = 64'd1; op_s[0] = 1'b0;
        serve(0, 0);
        check("wrap_sum_const", last_sum, 64'(0));
        check("wrap_zf_const", 64'(last_zf), 64'(1));
        check("wrap_of_const", 64'(last_of), 64'(0));

        // Reset while a response is pending.
        v[0] = 1'b1; v[1] = 1'b1;
        op_a[0] = 64'd9; op_b[0] = 64'd9; op_a[1] = 64'd4; op_b[1] = 64'd4;
        drive();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_valid", 64'(rsp_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        check("mid_rst_sum", rsp_sum, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'(1));

        // Fairness: both requesters always pending, consumer always ready.
        for (int n = 0; n < 4; n++) begin
            serve(0, 1);
            check("fair_grant_const", 64'(last_grant), 64'(n % 2));
        end

        // Backpressure, then the other requester is served next.
        serve(5, 1);
        check("bp_first_const", 64'(last_grant), 64'(0));
        serve(0, 1);
        check("bp_next_const", 64'(last_grant), 64'(1));

        // Subtract select: both requesters hold the same op so the grant order does not matter.
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; op_a[i] = 64'd3; op_b[i] = 64'd3; op_s[i] = 1'b1;
        end
        serve(0, 0);
        check("sub_sum_const", last_sum, SUB_EN ? 64'd0 : 64'd6);
        check("sub_zf_const", 64'(last_zf), SUB_EN ? 64'd1 : 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; op_a[i] = 64'h8000_0000_0000_0000; op_b[i] = 64'd1; op_s[i] = 1'b1;
        end
        serve(0, 0);
        check("sub_ovf_sum_const", last_sum,
              SUB_EN ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0001);
        check("sub_ovf_of_const", 64'(last_of), SUB_EN ? 64'd1 : 64'd0);
        // The remaining requester still has its copy pending; drain it.
        if (v[0] || v[1]) serve(0, 0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    v[i]    = 1'($urandom);
                    op_a[i] = pick();
                    op_b[i] = pick();
                    op_s[i] = 1'($urandom);
                end
            end
            if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
            serve($urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
